// File: rtl/aes_decrypt_core.sv
// AES-128 iterative inverse cipher: forward key walk to rk10, then one decryption round per clock
// with round keys regenerated backward. Optional rk10 cache for repeated keys: AES_DEC_KEY_CACHE_EN.
`timescale 1ns/1ps
module aes_decrypt_core #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] ciphertext,
  output logic [127:0] plaintext,
  output logic         ready,
  output logic         done
);
  if (NR != 10) begin : g_bad_nr
    $error("aes_decrypt_core supports only NR=10 (AES-128)");
  end

  // state | meaning
  // IDLE  | waiting for start, ready=1
  // KEXP  | forward key expansion rk0 -> rk10
  // ADDK  | initial AddRoundKey with rk10, step key back to rk9
  // ROUND | inverse rounds 9..1, key stepped back each cycle
  // FINAL | last round without InvMixColumns, publish plaintext
  typedef enum logic [2:0] {IDLE, KEXP, ADDK, ROUND, FINAL} state_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] forward_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] inverse_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n3 = k[31:0] ^ k[63:32];
    n2 = k[63:32] ^ k[95:64];
    n1 = k[95:64] ^ k[127:96];
    n0 = k[127:96] ^ sub_rot(n3) ^ {rc, 24'h0};
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(r+4*c) -: 8];
      o[127-32*c -: 8]  = gf_mul(a[0], 8'h0e) ^ gf_mul(a[1], 8'h0b) ^ gf_mul(a[2], 8'h0d) ^ gf_mul(a[3], 8'h09);
      o[119-32*c -: 8]  = gf_mul(a[0], 8'h09) ^ gf_mul(a[1], 8'h0e) ^ gf_mul(a[2], 8'h0b) ^ gf_mul(a[3], 8'h0d);
      o[111-32*c -: 8]  = gf_mul(a[0], 8'h0d) ^ gf_mul(a[1], 8'h09) ^ gf_mul(a[2], 8'h0e) ^ gf_mul(a[3], 8'h0b);
      o[103-32*c -: 8]  = gf_mul(a[0], 8'h0b) ^ gf_mul(a[1], 8'h0d) ^ gf_mul(a[2], 8'h09) ^ gf_mul(a[3], 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t       fsm;
  logic [3:0]   cnt;
  logic [127:0] st, rk;
  logic [127:0] rk_fwd, rk_inv, st_pre;

  assign rk_fwd = forward_expand(rk, rcon(cnt));
  assign rk_inv = inverse_expand(rk, rcon(cnt));
  assign st_pre = inv_sr_sb(st);

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] key_tag, cache_rk10;
  logic         cache_vld, cache_hit;

  assign cache_hit = cache_vld && (key == key_tag);

  // Tag is taken at start because key is not held; the entry only becomes valid once rk10 exists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_tag    <= '0;
      cache_rk10 <= '0;
      cache_vld  <= 1'b0;
    end else if (fsm == IDLE && start && !cache_hit) begin
      key_tag   <= key;
      cache_vld <= 1'b0;
    end else if (fsm == KEXP && cnt == 4'd10) begin
      cache_rk10 <= rk_fwd;
      cache_vld  <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      cnt       <= 4'd0;
      st        <= '0;
      rk        <= '0;
      plaintext <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            st    <= ciphertext;
            ready <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
            if (cache_hit) begin
              rk  <= cache_rk10;
              cnt <= 4'd10;
              fsm <= ADDK;
            end else begin
              rk  <= key;
              cnt <= 4'd1;
              fsm <= KEXP;
            end
`else
            rk  <= key;
            cnt <= 4'd1;
            fsm <= KEXP;
`endif
          end
        end
        KEXP: begin
          rk <= rk_fwd;
          if (cnt == 4'd10) fsm <= ADDK;
          else cnt <= cnt + 4'd1;
        end
        ADDK: begin
          st  <= st ^ rk;
          rk  <= rk_inv;
          cnt <= 4'd9;
          fsm <= ROUND;
        end
        ROUND: begin
          st  <= inv_mix_columns(st_pre ^ rk);
          rk  <= rk_inv;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) fsm <= FINAL;
        end
        FINAL: begin
          plaintext <= st_pre ^ rk;
          done      <= 1'b1;
          ready     <= 1'b1;
          fsm       <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decrypt_core.sv
// Bench for aes_decrypt_core: FIPS vectors, busy/reset handling and random blocks checked
// against an independent forward AES-128 model (ciphertext = encrypt(random plaintext)).
`timescale 1ns/1ps
module tb_aes_decrypt_core;
`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ABK = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ABC = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ABP = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] ZKC = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] ciphertext = '0;
  logic [127:0] plaintext;
  logic         ready, done;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]   sb [256];
  logic         m_vld = 1'b0;
  logic [127:0] m_tag = '0;

  aes_decrypt_core #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .ciphertext(ciphertext),
    .plaintext(plaintext), .ready(ready), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(a[7:0], b[7:0]) == 8'h01) inv = b[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[a] = s;
    end
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3, rc;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic int exp_lat(input logic [127:0] k);
    return (CACHE && m_vld && k == m_tag) ? 11 : 21;
  endfunction

  task automatic note_done(input logic [127:0] k);
    if (!(CACHE && m_vld && k == m_tag)) begin
      m_tag = k;
      m_vld = 1'b1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_vld = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] k, input logic [127:0] c, output logic [127:0] pt,
                           output int lat, output int busy_bad, output logic done_after);
    @(negedge clk);
    key = k;
    ciphertext = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom};
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
    lat = -1;
    busy_bad = 0;
    pt = '0;
    done_after = 1'b1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        pt = plaintext;
        if (!ready) busy_bad++;
      end else if (ready) busy_bad++;
    end
    if (lat > 0) begin
      @(posedge clk);
      #1;
      done_after = done;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (plaintext !== 128'h0) begin n_err++; $display("FAIL reset_pt: got %h expected 0", plaintext); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    m_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ready !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL idle_no_start: got ready=%b done=%b expected ready=1 done=0", ready, done);
    end
  endtask

  task automatic test_vectors();
    logic [127:0] vk [3];
    logic [127:0] vc [3];
    logic [127:0] vp [3];
    logic [127:0] pt;
    int lat, bad, el;
    logic da;
    vk[0] = C1K; vc[0] = C1C; vp[0] = C1P;
    vk[1] = ABK; vc[1] = ABC; vp[1] = ABP;
    vk[2] = '0;  vc[2] = ZKC; vp[2] = '0;
    for (int i = 0; i < 3; i++) begin
      el = exp_lat(vk[i]);
      run_block(vk[i], vc[i], pt, lat, bad, da);
      note_done(vk[i]);
      n_cmp++; if (pt !== vp[i]) begin n_err++; $display("FAIL vector%0d_pt: got %h expected %h", i, pt, vp[i]); end
      n_cmp++; if (lat !== el) begin n_err++; $display("FAIL vector%0d_latency: got %0d expected %0d", i, lat, el); end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL vector%0d_ready_busy: got %0d bad cycles expected 0", i, bad); end
      n_cmp++; if (da !== 1'b0) begin n_err++; $display("FAIL vector%0d_done_width: got done=%b after pulse expected 0", i, da); end
    end
  endtask

  task automatic test_busy();
    logic [127:0] pt;
    int lat, pulses, ready_hi;
    do_reset();
    @(negedge clk);
    key = C1K;
    ciphertext = C1C;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1; pulses = 0; ready_hi = 0; pt = '0;
    for (int n = 1; n <= 30; n++) begin
      if (n == 3) begin
        key = {$urandom, $urandom, $urandom, $urandom};
        ciphertext = {$urandom, $urandom, $urandom, $urandom};
      end
      start = (n == 5 || n == 15);
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (lat < 0) begin lat = n; pt = plaintext; end
      end
      if (n <= 20 && ready) ready_hi++;
    end
    start = 1'b0;
    note_done(C1K);
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL busy_pulses: got %0d expected 1", pulses); end
    n_cmp++; if (lat !== 21) begin n_err++; $display("FAIL busy_latency: got %0d expected 21", lat); end
    n_cmp++; if (pt !== C1P) begin n_err++; $display("FAIL busy_pt: got %h expected %h", pt, C1P); end
    n_cmp++; if (ready_hi !== 0) begin n_err++; $display("FAIL busy_ready: got %0d ready-high edges expected 0", ready_hi); end
  endtask

  task automatic test_reset_midop();
    logic [127:0] pt;
    int lat, bad, dseen, el;
    logic da;
    do_reset();
    run_block(ABK, ABC, pt, lat, bad, da);
    note_done(ABK);
    @(negedge clk);
    key = C1K;
    ciphertext = C1C;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 11; n++) @(posedge clk);
    #1;
    rst_n = 1'b0;
    dseen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) dseen++;
    end
    n_cmp++; if (plaintext !== 128'h0) begin n_err++; $display("FAIL midrst_pt: got %h expected 0", plaintext); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b expected 1", ready); end
    @(negedge clk);
    rst_n = 1'b1;
    m_vld = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) dseen++;
    end
    n_cmp++; if (dseen !== 0) begin n_err++; $display("FAIL midrst_done: got %0d pulses expected 0", dseen); end
    el = exp_lat(C1K);
    run_block(C1K, C1C, pt, lat, bad, da);
    note_done(C1K);
    n_cmp++; if (pt !== C1P) begin n_err++; $display("FAIL midrst_rerun_pt: got %h expected %h", pt, C1P); end
    n_cmp++; if (lat !== el) begin n_err++; $display("FAIL midrst_rerun_latency: got %0d expected %0d", lat, el); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ks [3];
    logic [127:0] cs [3];
    logic [127:0] ps [3];
    logic [127:0] pt;
    int lat, bad, el;
    logic da;
    ks[0] = C1K; cs[0] = C1C; ps[0] = C1P;
    ks[1] = C1K; cs[1] = C1C; ps[1] = C1P;
    ks[2] = ABK; cs[2] = ABC; ps[2] = ABP;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      el = exp_lat(ks[i]);
      run_block(ks[i], cs[i], pt, lat, bad, da);
      note_done(ks[i]);
      n_cmp++; if (pt !== ps[i]) begin n_err++; $display("FAIL b2b%0d_pt: got %h expected %h", i, pt, ps[i]); end
      n_cmp++; if (lat !== el) begin n_err++; $display("FAIL b2b%0d_latency: got %0d expected %0d", i, lat, el); end
    end
  endtask

  task automatic test_random();
    logic [127:0] k, p, c, pt, prev_k;
    int lat, bad, el;
    logic da;
    prev_k = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0 && $urandom_range(0, 2) == 0) k = prev_k;
      else k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      c = model_encrypt(k, p);
      el = exp_lat(k);
      run_block(k, c, pt, lat, bad, da);
      note_done(k);
      prev_k = k;
      n_cmp++; if (pt !== p) begin n_err++; $display("FAIL rand%0d_pt: got %h expected %h", i, pt, p); end
      n_cmp++; if (lat !== el) begin n_err++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, el); end
      n_cmp++; if (bad !== 0 || da !== 1'b0) begin
        n_err++; $display("FAIL rand%0d_handshake: got bad=%0d done_after=%b expected 0/0", i, bad, da);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (plaintext !== p) begin n_err++; $display("FAIL hold_pt: got %h expected %h", plaintext, p); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_vectors();
    test_busy();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
